pwm_multi: RTL and testbench

- Parametrised multi-channel PWM generator for the GPIO/Wishbone peripheral area.
- All channels share one timebase built from a prescaler and a period counter.
- Channel count, counter width and prescaler width are configurable.
- Compared with the single-mode generator, it adds:
  - edge-aligned and center-aligned modes
  - double-buffered (shadow) period/duty/mode updates, applied glitch-free at period boundaries
  - per-channel enable and polarity
  - a period-boundary tick for interrupt/DMA use.

---
 rtl/pwm_multi_pkg.sv | 18 +
 rtl/pwm_timebase.sv | 120 ++++++++++++
 rtl/pwm_multi.sv | 67 ++++++
 tb/tb_pwm_multi.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM generator: mode and direction
// encodings plus the helper that locates a channel's duty field in the packed bus.
package pwm_multi_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Lowest bit of channel ch's duty field in a bus of width-bit slices.
    function automatic int duty_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/center up-down counter, boundary detect
// and the double-buffered period/duty/mode registers swapped at boundaries.
module pwm_timebase
    import pwm_multi_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PRESC_WIDTH-1:0]        prescale,
    input  logic [CNT_WIDTH-1:0]          period,
    input  logic [CHANNELS*CNT_WIDTH-1:0] duty,
    input  logic                          center,
    input  logic                          load,
    output logic [CNT_WIDTH-1:0]          counter,
    output logic [CHANNELS*CNT_WIDTH-1:0] duty_act,
    output logic                          period_tick,
    output logic                          pending
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [PRESC_WIDTH-1:0]        presc_reg, presc_next;
    logic [CNT_WIDTH-1:0]          cnt_reg, cnt_next;
    dir_t                          dir_reg, dir_next;
    logic [CNT_WIDTH-1:0]          period_act_reg, period_pend_reg;
    logic [CHANNELS*CNT_WIDTH-1:0] duty_act_reg, duty_pend_reg;
    logic                          mode_act_reg, mode_pend_reg;
    logic                          pending_reg, tick_reg;
    logic                          presc_tick, boundary;

    always_comb begin
        presc_tick = (presc_reg == prescale);
        presc_next = presc_tick ? '0 : presc_reg + 1'b1;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        boundary   = 1'b0;
        if (presc_tick) begin
            if (mode_act_reg == MODE_EDGE) begin
                if (cnt_reg == period_act_reg) begin
                    cnt_next = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else if (period_act_reg == '0) begin
                cnt_next = '0;
                boundary = 1'b1;
            end else if (dir_reg == DIR_UP) begin
                if (cnt_reg == period_act_reg) begin
                    // With P=1 the turnaround point is also the last count of the period.
                    if (period_act_reg == CNT_ONE) begin
                        cnt_next = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                        dir_next = DIR_DOWN;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                if (cnt_reg == CNT_ONE) begin
                    cnt_next = '0;
                    dir_next = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_reg       <= '0;
            cnt_reg         <= '0;
            dir_reg         <= DIR_UP;
            period_act_reg  <= '0;
            duty_act_reg    <= '0;
            mode_act_reg    <= MODE_EDGE;
            period_pend_reg <= '0;
            duty_pend_reg   <= '0;
            mode_pend_reg   <= MODE_EDGE;
            pending_reg     <= 1'b0;
            tick_reg        <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            tick_reg  <= boundary;
            if (boundary) begin
                // A load landing on the boundary bypasses the pending stage.
                if (load) begin
                    period_act_reg <= period;
                    duty_act_reg   <= duty;
                    mode_act_reg   <= center;
                end else if (pending_reg) begin
                    period_act_reg <= period_pend_reg;
                    duty_act_reg   <= duty_pend_reg;
                    mode_act_reg   <= mode_pend_reg;
                end
                pending_reg <= 1'b0;
            end else if (load) begin
                period_pend_reg <= period;
                duty_pend_reg   <= duty;
                mode_pend_reg   <= center;
                pending_reg     <= 1'b1;
            end
        end
    end

    assign counter     = cnt_reg;
    assign duty_act    = duty_act_reg;
    assign period_tick = tick_reg;
    assign pending     = pending_reg;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared timebase, per-channel unsigned compare
// with enable/polarity applied in a single output register stage.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PRESC_WIDTH-1:0]        prescale,
    input  logic [CNT_WIDTH-1:0]          period,
    input  logic [CHANNELS*CNT_WIDTH-1:0] duty,
    input  logic                          center,
    input  logic                          load,
    input  logic [CHANNELS-1:0]           enable,
    input  logic [CHANNELS-1:0]           polarity,
    output logic [CHANNELS-1:0]           pwm,
    output logic                          period_tick,
    output logic                          pending
);

    logic [CNT_WIDTH-1:0]          counter;
    logic [CHANNELS*CNT_WIDTH-1:0] duty_act;
    logic [CHANNELS-1:0]           raw;
    logic [CHANNELS-1:0]           pwm_reg, pwm_next;

    pwm_timebase #(
        .CHANNELS   (CHANNELS),
        .CNT_WIDTH  (CNT_WIDTH),
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .prescale   (prescale),
        .period     (period),
        .duty       (duty),
        .center     (center),
        .load       (load),
        .counter    (counter),
        .duty_act   (duty_act),
        .period_tick(period_tick),
        .pending    (pending)
    );

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign raw[gi] = (counter < duty_act[duty_lsb(gi, CNT_WIDTH) +: CNT_WIDTH]);
        end
    endgenerate

    // Disabled channels sit at their inactive level, which is the polarity bit.
    assign pwm_next = (enable & (raw ^ polarity)) | (~enable & polarity);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_reg <= '0;
        end else begin
            pwm_reg <= pwm_next;
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: expected per-cycle outputs are queued when stimulus
// is applied and popped/checked on each falling edge.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  prescale;
    logic [15:0] period;
    logic [63:0] duty;
    logic        center;
    logic        load;
    logic [3:0]  enable;
    logic [3:0]  polarity;
    logic [3:0]  pwm;
    logic        period_tick;
    logic        pending;

    typedef struct {
        logic [3:0] pwm;
        logic       tick;
        logic       pend;
        logic       chk_tick;
        logic       chk_pend;
    } exp_t;

    exp_t  sb[$];
    string phase;
    int    passed = 0;
    int    total  = 0;
    int    cycnt  = 0;

    always #5 clk = ~clk;

    pwm_multi #(
        .CHANNELS   (4),
        .CNT_WIDTH  (16),
        .PRESC_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prescale   (prescale),
        .period     (period),
        .duty       (duty),
        .center     (center),
        .load       (load),
        .enable     (enable),
        .polarity   (polarity),
        .pwm        (pwm),
        .period_tick(period_tick),
        .pending    (pending)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s/%s cycle=%0d observed=%h expected=%h", phase, tag, cycnt, obs, exp);
    endtask

    task automatic push(input logic [3:0] p, input logic t, input logic pe,
                        input logic ct = 1'b1, input logic cp = 1'b1);
        exp_t e;
        e.pwm = p; e.tick = t; e.pend = pe; e.chk_tick = ct; e.chk_pend = cp;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cycnt++;
        end
    endtask

    // Advance one clock and compare against the oldest queued expectation.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        cycnt++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pwm", 16'(pwm), 16'(e.pwm));
            if (e.chk_tick) chk("period_tick", 16'(period_tick), 16'(e.tick));
            if (e.chk_pend) chk("pending", 16'(pending), 16'(e.pend));
        end
    endtask

    task automatic drain();
        while (sb.size() != 0) cyc();
        $display("phase %s done: %0d/%0d", phase, passed, total);
    endtask

    // Step until the queued update has been applied, bounded to 100 clocks.
    task automatic wait_applied();
        int n = 0;
        while (pending === 1'b1 && n < 100) begin
            idle(1);
            n++;
        end
        chk("apply_timeout", 16'(pending), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, c;
        rst = 1'b0; prescale = 8'd0; period = 16'd0; duty = 64'd0;
        center = 1'b0; load = 1'b0; enable = 4'hF; polarity = 4'h0;

        phase = "reset";
        idle(3);
        push(4'b0000, 1'b0, 1'b0);
        drain();

        phase = "idle_p0";
        rst = 1'b1;
        for (int i = 0; i < 3; i++) push(4'b0000, 1'b1, 1'b0);
        drain();

        // Load lands on a boundary (P_act=0), so it is applied at once.
        phase = "edge_p9";
        period = 16'd9; duty = 64'd3; center = 1'b0; load = 1'b1;
        push(4'b0000, 1'b1, 1'b0);
        cyc();
        load = 1'b0;
        for (int k = 1; k <= 33; k++)
            push({3'b000, ((k - 1) % 10) < 3}, (k % 10) == 0, 1'b0);
        drain();

        phase = "shadow";
        period = 16'd19; duty = 64'd10; load = 1'b1;
        push(4'b0000, 1'b0, 1'b1);
        cyc();
        load = 1'b0;
        for (int k = 35; k <= 39; k++) push(4'b0000, 1'b0, 1'b1);
        push(4'b0000, 1'b1, 1'b0);
        for (int k = 41; k <= 100; k++)
            push({3'b000, ((k - 41) % 20) < 10}, ((k - 40) % 20) == 0, 1'b0);
        drain();

        phase = "duty_limits";
        duty = {16'd20, 16'd0, 16'd20, 16'd0};
        polarity = 4'b1100; load = 1'b1;
        idle(1);
        load = 1'b0;
        chk("pending_set", 16'(pending), 16'd1);
        wait_applied();
        idle(1);
        for (int i = 0; i < 30; i++) push(4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        phase = "disabled";
        enable = 4'b0000;
        for (int i = 0; i < 5; i++) push(4'b1100, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        phase = "center_p8";
        enable = 4'hF; polarity = 4'h0; prescale = 8'd1;
        period = 16'd8; duty = {16'd0, 16'd9, 16'd4, 16'd0}; center = 1'b1; load = 1'b1;
        idle(1);
        load = 1'b0;
        wait_applied();
        for (int k = 1; k <= 64; k++) begin
            t = ((k - 1) / 2) % 16;
            c = (t <= 8) ? t : 16 - t;
            push({1'b0, 1'b1, c < 4, 1'b0}, (k % 32) == 0, 1'b0);
        end
        drain();

        phase = "reset_mid";
        period = 16'd5; duty = 64'd0; load = 1'b1;
        idle(1);
        load = 1'b0;
        chk("pending_before_rst", 16'(pending), 16'd1);
        rst = 1'b0; prescale = 8'd0;
        push(4'b0000, 1'b0, 1'b0);
        push(4'b0000, 1'b0, 1'b0);
        drain();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) push(4'b0000, 1'b1, 1'b0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
